// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries BTB predictions IF->EX and resolves them into redirect/flush.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int XLEN  = 32
`ifdef BRU_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            valid_if_i,
    input  logic [XLEN-1:0] pc_if_i,
    input  logic            hit_if_i,
    input  logic [XLEN-1:0] pred_pc_if_i,
    input  logic            ctrl_ex_i,
    input  logic            taken_ex_i,
    input  logic [XLEN-1:0] target_ex_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic [1:0]      mispred_o,
    output logic            hit_ex_o,
    output logic [XLEN-1:0] pc_ex_o,
    output logic            busy_o
`ifdef BRU_PERF_CNT_EN
    , output logic [CNT_W-1:0] n_ctrl_o
    , output logic [CNT_W-1:0] n_mispred_o
    , output logic [CNT_W-1:0] n_wrong_tgt_o
`endif
);

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t          r_state;
    logic            r_id_valid, r_id_hit;
    logic [XLEN-1:0] r_id_pc, r_id_pred;
    logic            r_ex_valid, r_ex_hit;
    logic [XLEN-1:0] r_ex_pc, r_ex_pred;

    logic            w_res_en;
    logic            w_taken;
    logic [1:0]      w_mispred;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect;

    assign w_res_en = r_ex_valid & ~stall_i & (r_state == IDLE);
    assign w_taken  = ctrl_ex_i & taken_ex_i;

    always_comb begin
        w_mispred     = 2'b00;
        w_redirect_pc = '0;
        if (w_res_en) begin
            if (r_ex_hit && !w_taken) begin
                w_mispred     = 2'b01;
                w_redirect_pc = r_ex_pc + XLEN'(4);
            end else if (!r_ex_hit && w_taken) begin
                w_mispred     = 2'b10;
                w_redirect_pc = target_ex_i;
            end else if (r_ex_hit && w_taken && (target_ex_i != r_ex_pred)) begin
                w_mispred     = 2'b11;
                w_redirect_pc = target_ex_i;
            end
        end
    end

    assign w_redirect    = (w_mispred != 2'b00);
    assign redirect_o    = w_redirect;
    assign flush_o       = w_redirect;
    assign mispred_o     = w_mispred;
    assign redirect_pc_o = w_redirect_pc;
    assign hit_ex_o      = r_ex_valid & r_ex_hit;
    assign pc_ex_o       = r_ex_valid ? r_ex_pc : '0;
    assign busy_o        = (r_state == FLUSH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_id_valid <= 1'b0;
            r_id_hit   <= 1'b0;
            r_id_pc    <= '0;
            r_id_pred  <= '0;
            r_ex_valid <= 1'b0;
            r_ex_hit   <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_pred  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stall_i) begin
                        if (w_redirect) begin
                            // Younger instructions and this cycle's fetch are wrong-path.
                            r_state    <= FLUSH;
                            r_id_valid <= 1'b0;
                            r_ex_valid <= 1'b0;
                        end else begin
                            r_id_valid <= valid_if_i;
                            r_id_hit   <= hit_if_i;
                            r_id_pc    <= pc_if_i;
                            r_id_pred  <= pred_pc_if_i;
                            r_ex_valid <= r_id_valid;
                            r_ex_hit   <= r_id_hit;
                            r_ex_pc    <= r_id_pc;
                            r_ex_pred  <= r_id_pred;
                        end
                    end
                end
                FLUSH: begin
                    r_state <= IDLE;
                    // Fetch now presents the redirected PC; take it as we leave.
                    if (!stall_i) begin
                        r_id_valid <= valid_if_i;
                        r_id_hit   <= hit_if_i;
                        r_id_pc    <= pc_if_i;
                        r_id_pred  <= pred_pc_if_i;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            n_ctrl_o      <= '0;
            n_mispred_o   <= '0;
            n_wrong_tgt_o <= '0;
        end else begin
            if (w_res_en && ctrl_ex_i)   n_ctrl_o      <= sat_inc(n_ctrl_o);
            if (w_redirect)              n_mispred_o   <= sat_inc(n_mispred_o);
            if (w_mispred == 2'b11)      n_wrong_tgt_o <= sat_inc(n_wrong_tgt_o);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed-vector bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        valid_if = 1'b0;
    logic [31:0] pc_if = '0;
    logic        hit_if = 1'b0;
    logic [31:0] pred_if = '0;
    logic        ctrl_ex = 1'b0;
    logic        taken_ex = 1'b0;
    logic [31:0] target_ex = '0;
    logic        redirect, flush, hit_ex, busy;
    logic [31:0] redirect_pc, pc_ex;
    logic [1:0]  mispred;
`ifdef BRU_PERF_CNT_EN
    logic [15:0] n_ctrl, n_mispred, n_wrong_tgt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .valid_if_i(valid_if), .pc_if_i(pc_if), .hit_if_i(hit_if), .pred_pc_if_i(pred_if),
        .ctrl_ex_i(ctrl_ex), .taken_ex_i(taken_ex), .target_ex_i(target_ex),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc), .flush_o(flush),
        .mispred_o(mispred), .hit_ex_o(hit_ex), .pc_ex_o(pc_ex), .busy_o(busy)
`ifdef BRU_PERF_CNT_EN
        , .n_ctrl_o(n_ctrl), .n_mispred_o(n_mispred), .n_wrong_tgt_o(n_wrong_tgt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic s, input logic v, input logic [31:0] pc, input logic h,
                       input logic [31:0] pr, input logic c, input logic t, input logic [31:0] tg);
        @(negedge clk);
        stall = s; valid_if = v; pc_if = pc; hit_if = h; pred_if = pr;
        ctrl_ex = c; taken_ex = t; target_ex = tg;
        #1;
    endtask

    task automatic check_res(input string tag, input logic r, input logic [1:0] m, input logic [31:0] rpc);
        check_eq({tag, ".redirect"}, 32'(redirect), 32'(r));
        check_eq({tag, ".flush"}, 32'(flush), 32'(r));
        check_eq({tag, ".mispred"}, 32'(mispred), 32'(m));
        check_eq({tag, ".redirect_pc"}, redirect_pc, rpc);
    endtask

    initial begin
        #2;
        check_res("reset", 1'b0, 2'b00, 32'h0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.hit_ex", 32'(hit_ex), 32'd0);
        check_eq("reset.pc_ex", pc_ex, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Correct prediction: 0x100 hit -> 0x200, resolves taken to 0x200.
        cyc(0, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0);
        cyc(0, 1, 32'h104, 1, 32'h300, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h200);
        check_res("ok", 1'b0, 2'b00, 32'h0);
        check_eq("ok.hit_ex", 32'(hit_ex), 32'd1);
        check_eq("ok.pc_ex", pc_ex, 32'h100);

        // Predicted taken, resolves not taken.
        cyc(0, 1, 32'h108, 0, 32'h0, 1, 0, 32'h0);
        check_res("m01", 1'b1, 2'b01, 32'h108);
        check_eq("m01.pc_ex", pc_ex, 32'h104);
        cyc(0, 1, 32'h108, 0, 32'h0, 0, 0, 32'h0);
        check_eq("m01.busy", 32'(busy), 32'd1);
        check_eq("m01.pc_ex_inv", pc_ex, 32'h0);
        check_eq("m01.hit_ex_inv", 32'(hit_ex), 32'd0);
        check_res("m01.flush_cyc", 1'b0, 2'b00, 32'h0);

        // Predicted not taken, resolves taken to 0x40; wrong-path 0x10c/0x110 must vanish.
        cyc(0, 1, 32'h10c, 0, 32'h0, 0, 0, 32'h0);
        check_eq("m10.busy_clr", 32'(busy), 32'd0);
        cyc(0, 1, 32'h110, 0, 32'h0, 1, 1, 32'h40);
        check_res("m10", 1'b1, 2'b10, 32'h40);
        check_eq("m10.pc_ex", pc_ex, 32'h108);
        cyc(0, 1, 32'h40, 1, 32'h500, 0, 0, 32'h0);
        check_eq("m10.busy", 32'(busy), 32'd1);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("m10.no_wrong_path", pc_ex, 32'h0);

        // Taken with wrong target.
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h504);
        check_eq("m11.pc_ex", pc_ex, 32'h40);
        check_eq("m11.hit_ex", 32'(hit_ex), 32'd1);
        check_res("m11", 1'b1, 2'b11, 32'h504);
`ifdef BRU_PERF_CNT_EN
        check_eq("cnt.wrong_before", 32'(n_wrong_tgt), 32'd0);
`endif
        cyc(0, 1, 32'h504, 1, 32'h600, 0, 0, 32'h0);
`ifdef BRU_PERF_CNT_EN
        check_eq("cnt.ctrl", 32'(n_ctrl), 32'd4);
        check_eq("cnt.mispred", 32'(n_mispred), 32'd3);
        check_eq("cnt.wrong_after", 32'(n_wrong_tgt), 32'd1);
`endif

        // Pending mispredict held off by a 3-cycle stall.
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 32'h999, 1, 32'h0, 1, 0, 32'h0);
            check_res($sformatf("stall%0d", i), 1'b0, 2'b00, 32'h0);
            check_eq($sformatf("stall%0d.pc_ex", i), pc_ex, 32'h504);
        end
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        check_res("unstall", 1'b1, 2'b01, 32'h508);

        // PC+4 wraps to zero.
        cyc(0, 1, 32'hFFFFFFFC, 1, 32'h700, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("wrap.pc_ex", pc_ex, 32'hFFFFFFFC);
        check_res("wrap", 1'b1, 2'b01, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        check_eq("wrap.busy", 32'(busy), 32'd1);
`ifdef BRU_PERF_CNT_EN
        check_eq("cnt.ctrl2", 32'(n_ctrl), 32'd5);
        check_eq("cnt.mispred2", 32'(n_mispred), 32'd5);
`endif

        // Asynchronous reset in the middle of FLUSH.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_flush.busy", 32'(busy), 32'd0);
        check_eq("rst_flush.pc_ex", pc_ex, 32'h0);
        check_res("rst_flush", 1'b0, 2'b00, 32'h0);
`ifdef BRU_PERF_CNT_EN
        check_eq("rst_flush.cnt", 32'(n_mispred), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h80);
        check_eq("post_rst.busy", 32'(busy), 32'd0);
        check_res("post_rst", 1'b0, 2'b00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
